// File: rtl/reg_file.sv
// rtl/reg_file.sv - four-slot credential store with per-slot valid flag
// Save/delete commit on the clock edge; the read port is purely combinational.
module reg_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  save,
  input  logic [ADDR_WIDTH-1:0] save_addr,
  input  logic                  delete,
  input  logic [ADDR_WIDTH-1:0] del_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH:0]   data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_d  [DEPTH];
  logic                  valid_q [DEPTH];
  logic                  valid_d [DEPTH];

  // Delete is evaluated after save so it wins when both target one slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i]  = data_q[i];
      valid_d[i] = valid_q[i];
      if (save && (save_addr == ADDR_WIDTH'(i))) begin
        data_d[i]  = data_in;
        valid_d[i] = 1'b1;
      end
      if (delete && (del_addr == ADDR_WIDTH'(i))) begin
        data_d[i]  = '0;
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= data_d[i];
        valid_q[i] <= valid_d[i];
      end
    end
  end

  assign data_out = {valid_q[read_addr], data_q[read_addr]};

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file against an array model
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        save;
  logic [1:0]  save_addr;
  logic        delete;
  logic [1:0]  del_addr;
  logic [1:0]  read_addr;
  logic [16:0] data_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  addr;
    logic [16:0] exp;
  } item_t;

  item_t exp_q[$];

  bit          m_valid [4];
  logic [15:0] m_data  [4];

  reg_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .save      (save),
    .save_addr (save_addr),
    .delete    (delete),
    .del_addr  (del_addr),
    .read_addr (read_addr),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    item_t it;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      checks++;
      if (data_out !== it.exp) begin
        errors++;
        $display("FAIL read slot %0d: got %h expected %h", it.addr, data_out, it.exp);
      end
    end
  end

  // Present inputs for one cycle; the read reflects the state before this edge commits.
  task automatic cycle(input bit rst, input bit sv, input logic [1:0] sa,
                       input logic [15:0] din, input bit dl, input logic [1:0] da,
                       input logic [1:0] ra, input bit chk);
    item_t it;
    reset     = rst;
    save      = sv;
    save_addr = sa;
    data_in   = din;
    delete    = dl;
    del_addr  = da;
    read_addr = ra;
    if (chk) begin
      it.addr = ra;
      it.exp  = m_valid[ra] ? {1'b1, m_data[ra]} : 17'h00000;
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = 16'h0;
      end
    end else begin
      if (sv) begin
        m_valid[sa] = 1'b1;
        m_data[sa]  = din;
      end
      if (dl) begin
        m_valid[da] = 1'b0;
        m_data[da]  = 16'h0;
      end
    end
    save   = 1'b0;
    delete = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ra);
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, ra, 1'b1);
  endtask

  task automatic rd_all();
    for (int i = 0; i < 4; i++) rd(2'(i));
  endtask

  initial begin
    reset = 1'b1; save = 1'b0; delete = 1'b0;
    save_addr = '0; del_addr = '0; read_addr = '0; data_in = '0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 1'b0);
    cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 1'b0);
    rd_all();

    cycle(1'b0, 1'b1, 2'd1, 16'hFFFF, 1'b0, 2'd0, 2'd1, 1'b1);
    rd(2'd1);
    rd(2'd0);

    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd1, 1'b1);
    rd_all();

    cycle(1'b0, 1'b1, 2'd0, 16'h1234, 1'b0, 2'd0, 2'd0, 1'b1);
    cycle(1'b0, 1'b1, 2'd1, 16'h5678, 1'b0, 2'd0, 2'd0, 1'b1);
    cycle(1'b0, 1'b1, 2'd2, 16'h9ABC, 1'b0, 2'd0, 2'd1, 1'b1);
    cycle(1'b0, 1'b1, 2'd3, 16'hDEF0, 1'b0, 2'd0, 2'd2, 1'b1);
    cycle(1'b0, 1'b1, 2'd2, 16'hAAAA, 1'b0, 2'd0, 2'd3, 1'b1);
    rd_all();

    cycle(1'b0, 1'b1, 2'd3, 16'h4321, 1'b1, 2'd0, 2'd3, 1'b1);
    rd_all();
    cycle(1'b0, 1'b1, 2'd2, 16'h7777, 1'b1, 2'd2, 2'd2, 1'b1);
    rd_all();

    cycle(1'b1, 1'b1, 2'd1, 16'hBEEF, 1'b0, 2'd0, 2'd1, 1'b1);
    rd_all();

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom), 1'b1);
    end
    rd_all();

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
